// File: rtl/pmu_host_driver_if.sv
// Host-side streams of the PMU driver: operand pairs in, lane results out.
// master is the host environment, slave is the driver block.
interface pmu_host_driver_if #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_W      = DATA_WIDTH + 1
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_a;
    logic [DATA_WIDTH-1:0] s_b;
    logic                  m_valid;
    logic                  m_ready;
    logic [OUT_W-1:0]      m_data;
    logic                  m_last;

    modport master (
        output s_valid, s_a, s_b, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_a, s_b, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/pmu_host_driver.sv
// Sequences one PMU batch: clear, load NUM_LANES pairs, wait out the PMU
// pipeline, capture, then drain every lane result onto the output stream.
module pmu_host_driver #(
    parameter int NUM_LANES   = 240,
    parameter int DATA_WIDTH  = 16,
    parameter int PMU_LATENCY = 2,
    parameter int BATCH_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pmu_host_driver_if.slave      bus_io,
    output logic                  pmu_rst_o,
    output logic                  load_en_o,
    output logic [DATA_WIDTH-1:0] dinA_o,
    output logic [DATA_WIDTH-1:0] dinB_o,
    output logic                  compute_start_o,
    output logic                  read_en_o,
    input  logic [DATA_WIDTH:0]   pmu_dout_i,
    input  logic                  pmu_valid_i,
    input  logic                  pmu_done_i,
    output logic                  busy_o,
    output logic [BATCH_W-1:0]    batch_cnt_o,
    output logic                  err_o
);
    localparam int OUT_W = DATA_WIDTH + 1;
    localparam int CNT_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [CNT_W-1:0] LANE_LAST = CNT_W'(NUM_LANES - 1);
    localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'((PMU_LATENCY > 0) ? PMU_LATENCY - 1 : 0);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, WAIT, CAPTURE, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [BATCH_W-1:0] batch_q, batch_d;
    logic               err_q, err_d;
    // Registered one-hot decodes of the state, so no output depends on inputs
    // except the handshake-qualified strobes.
    logic               ready_q, clr_q, cap_q, drain_q, busy_q, last_q;
    logic               m_hs;

    assign load_en_o       = ready_q & bus_io.s_valid;
    assign dinA_o          = ready_q ? bus_io.s_a : '0;
    assign dinB_o          = ready_q ? bus_io.s_b : '0;
    assign bus_io.s_ready  = ready_q;
    assign bus_io.m_valid  = drain_q & pmu_valid_i;
    assign bus_io.m_data   = drain_q ? pmu_dout_i : {OUT_W{1'b0}};
    assign bus_io.m_last   = last_q;
    assign m_hs            = bus_io.m_valid & bus_io.m_ready;
    assign read_en_o       = m_hs & ~last_q;
    assign pmu_rst_o       = clr_q;
    assign compute_start_o = cap_q;
    assign busy_o          = busy_q;
    assign batch_cnt_o     = batch_q;
    assign err_o           = err_q;

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        lat_cnt_d = lat_cnt_q;
        batch_d   = batch_q;
        // The wrapper must flag its last lane exactly when we expect it.
        err_d     = err_q | (drain_q & ((last_q != pmu_done_i) | ~pmu_valid_i));
        case (state_q)
            IDLE:    if (bus_io.s_valid) state_d = CLEAR;
            CLEAR:   state_d = LOAD;
            LOAD: begin
                if (load_en_o) begin
                    if (in_cnt_q == LANE_LAST) begin
                        in_cnt_d = '0;
                        state_d  = (PMU_LATENCY > 0) ? WAIT : CAPTURE;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    lat_cnt_d = '0;
                    state_d   = CAPTURE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            CAPTURE: state_d = DRAIN;
            DRAIN: begin
                if (m_hs) begin
                    if (last_q) begin
                        out_cnt_d = '0;
                        batch_d   = batch_q + 1'b1;
                        state_d   = IDLE;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            lat_cnt_q <= '0;
            batch_q   <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            clr_q     <= 1'b0;
            cap_q     <= 1'b0;
            drain_q   <= 1'b0;
            busy_q    <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            lat_cnt_q <= lat_cnt_d;
            batch_q   <= batch_d;
            err_q     <= err_d;
            ready_q   <= (state_d == LOAD);
            clr_q     <= (state_d == CLEAR);
            cap_q     <= (state_d == CAPTURE);
            drain_q   <= (state_d == DRAIN);
            busy_q    <= (state_d != IDLE);
            last_q    <= (state_d == DRAIN) && (out_cnt_d == LANE_LAST);
        end
    end
endmodule
